multi_lane_pipeline_reg: RTL and testbench

Parametrised N-lane pipeline register with per-lane flush, a group-level valid/ready handshake and an optional one-group skid buffer. It succeeds the fixed two-lane decode-to-execute register in the multi-issue core and sits at any stage boundary (D→E, E→M, M→W). Each lane carries an opaque packed payload of control and data fields. Lanes in one issue group advance together; flush acts per lane.

---
 rtl/multi_lane_pipeline_reg.sv | 113 +++++++++++
 tb/tb_multi_lane_pipeline_reg.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_lane_pipeline_reg.sv
// N-lane pipeline register: lanes of one issue group advance together under a
// group-level valid/ready handshake, flush kills individual lanes, optional skid group.
module multi_lane_pipeline_reg #(
    parameter int LANES = 2,
    parameter int WIDTH = 160,
    parameter int SKID  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES-1:0]       flush,
    input  logic [LANES-1:0]       in_valid,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   in_ready,
    output logic [LANES-1:0]       out_valid,
    output logic [LANES*WIDTH-1:0] out_data,
    input  logic                   out_ready,
    output logic [1:0]             occupancy
);
    localparam int DW = LANES * WIDTH;

    // Handshake: a group transfers on a clock edge where (|in_valid) & in_ready
    // upstream, and where (|out_valid) & out_ready downstream; all lanes move together.

    logic [LANES-1:0] mv, sv, mv_n, sv_n;
    logic [DW-1:0]    md, sd, md_n, sd_n;
    logic             ready_q;

    // Flush-masked views; a lane whose valid is 0 always carries payload 0.
    logic [LANES-1:0] mv_f, sv_f, av_f;
    logic [DW-1:0]    md_f, sd_f, ad_f;
    logic             m_full, m_full_f, s_full_f, fire, accept, m_adv;

    always_comb begin
        mv_f = mv & ~flush;
        sv_f = sv & ~flush;
        av_f = in_valid & ~flush;
        md_f = '0;
        sd_f = '0;
        ad_f = '0;
        for (int i = 0; i < LANES; i++) begin
            if (mv_f[i]) md_f[i*WIDTH +: WIDTH] = md[i*WIDTH +: WIDTH];
            if (sv_f[i]) sd_f[i*WIDTH +: WIDTH] = sd[i*WIDTH +: WIDTH];
            if (av_f[i]) ad_f[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign m_full   = |mv;
    assign m_full_f = |mv_f;
    assign s_full_f = |sv_f;
    assign fire     = m_full & out_ready;
    assign accept   = (|in_valid) & in_ready;
    assign m_adv    = !m_full_f || fire;

    generate
        if (SKID != 0) begin : g_skid_ready
            assign in_ready = ready_q;
        end else begin : g_comb_ready
            assign in_ready = !m_full || out_ready;
        end
    endgenerate

    always_comb begin
        mv_n = mv_f;
        md_n = md_f;
        sv_n = '0;
        sd_n = '0;
        if (SKID != 0) begin
            if (m_adv) begin
                // S is older than anything arriving now, so it always goes first.
                if (s_full_f) begin
                    mv_n = sv_f;
                    md_n = sd_f;
                end else if (accept) begin
                    mv_n = av_f;
                    md_n = ad_f;
                end else begin
                    mv_n = '0;
                    md_n = '0;
                end
            end else if (accept) begin
                sv_n = av_f;
                sd_n = ad_f;
            end else begin
                sv_n = sv_f;
                sd_n = sd_f;
            end
        end else if (m_adv) begin
            mv_n = accept ? av_f : '0;
            md_n = accept ? ad_f : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mv      <= '0;
            md      <= '0;
            sv      <= '0;
            sd      <= '0;
            ready_q <= 1'b1;
        end else begin
            mv      <= mv_n;
            md      <= md_n;
            sv      <= sv_n;
            sd      <= sd_n;
            ready_q <= ~|sv_n;
        end
    end

    assign out_valid = mv;
    assign out_data  = md;
    assign occupancy = {1'b0, m_full} + {1'b0, |sv};

endmodule

// File: tb/tb_multi_lane_pipeline_reg.sv
// Bench for multi_lane_pipeline_reg: a skid and a no-skid instance share the
// same directed stimulus and are both checked each cycle against a group-queue model.
module tb_multi_lane_pipeline_reg;
    localparam int L = 2;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [L-1:0]  flush, in_valid;
    logic [63:0]   in_data;
    logic          out_ready;

    logic          rdy1, rdy0;
    logic [L-1:0]  ov1, ov0;
    logic [63:0]   od1, od0;
    logic [1:0]    occ1, occ0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multi_lane_pipeline_reg #(.LANES(L), .WIDTH(W), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_ready(out_ready),
        .occupancy(occ1)
    );

    multi_lane_pipeline_reg #(.LANES(L), .WIDTH(W), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_ready(out_ready),
        .occupancy(occ0)
    );

    // ---------------- model: an ordered list of held groups ----------------
    typedef struct packed {
        logic [L-1:0] v;
        logic [63:0]  d;
    } grp_t;

    typedef struct {
        grp_t g[2];
        int   n;
    } mstate_t;

    mstate_t s1, s0;
    bit      started = 0;

    function automatic grp_t mask(grp_t g, logic [L-1:0] keep);
        grp_t r;
        r.v = g.v & keep;
        r.d = g.d;
        for (int i = 0; i < L; i++)
            if (!r.v[i]) r.d[i*W +: W] = '0;
        return r;
    endfunction

    function automatic bit exp_ready(mstate_t s, bit skid, logic ordy);
        if (skid) return (s.n < 2);
        return (s.n == 0) || ordy;
    endfunction

    function automatic mstate_t mstep(mstate_t s, bit skid, logic r, logic [L-1:0] fl,
                                      logic [L-1:0] iv, logic [63:0] id, logic ordy);
        mstate_t o;
        grp_t    t[2];
        grp_t    a;
        grp_t    m;
        int      k;
        bit      rd;
        rd = exp_ready(s, skid, ordy);
        o = s;
        if (r) begin
            o.n = 0;
            return o;
        end
        if (o.n > 0 && ordy) begin
            o.g[0] = o.g[1];
            o.n--;
        end
        k = 0;
        t[0] = '0;
        t[1] = '0;
        for (int i = 0; i < o.n; i++) begin
            m = mask(o.g[i], ~fl);
            if (|m.v) begin
                t[k] = m;
                k++;
            end
        end
        o.g[0] = t[0];
        o.g[1] = t[1];
        o.n = k;
        if ((|iv) && rd) begin
            a.v = iv;
            a.d = id;
            a = mask(a, ~fl);
            if (|a.v) begin
                o.g[o.n] = a;
                o.n++;
            end
        end
        return o;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        s1 = mstep(s1, 1'b1, rst, flush, in_valid, in_data, out_ready);
        s0 = mstep(s0, 1'b0, rst, flush, in_valid, in_data, out_ready);
        if (rst) started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("skid out_valid", {62'd0, ov1}, s1.n > 0 ? {62'd0, s1.g[0].v} : 64'd0);
            check("skid out_data", od1, s1.n > 0 ? s1.g[0].d : 64'd0);
            check("skid occupancy", {62'd0, occ1}, 64'(s1.n));
            check("skid in_ready", {63'd0, rdy1}, {63'd0, exp_ready(s1, 1'b1, out_ready)});
            check("noskid out_valid", {62'd0, ov0}, s0.n > 0 ? {62'd0, s0.g[0].v} : 64'd0);
            check("noskid out_data", od0, s0.n > 0 ? s0.g[0].d : 64'd0);
            check("noskid occupancy", {62'd0, occ0}, 64'(s0.n));
            check("noskid in_ready", {63'd0, rdy0}, {63'd0, exp_ready(s0, 1'b0, out_ready)});
        end
    end

    // ---------------- driver ----------------
    task automatic drive(logic r, logic [L-1:0] iv, logic [63:0] id, logic [L-1:0] fl,
                         logic ordy);
        rst       = r;
        in_valid  = iv;
        in_data   = id;
        flush     = fl;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic pin_out(string name, logic [L-1:0] v, logic [63:0] d, logic [1:0] occ,
                           logic rdy);
        check({name, " valid"}, {62'd0, ov1}, {62'd0, v});
        check({name, " data"}, od1, d);
        check({name, " occ"}, {62'd0, occ1}, {62'd0, occ});
        check({name, " ready"}, {63'd0, rdy1}, {63'd0, rdy});
    endtask

    localparam logic [63:0] G1 = {32'hA1A1_0001, 32'hA0A0_0001};
    localparam logic [63:0] G2 = {32'hA1A1_0002, 32'hA0A0_0002};
    localparam logic [63:0] G3 = {32'hA1A1_0003, 32'hA0A0_0003};
    localparam logic [63:0] XY = {32'h0000_00BB, 32'h0000_00AA};
    localparam logic [63:0] PQ = {32'h0000_00DD, 32'h0000_00CC};

    initial begin
        logic [63:0] g;
        rst = 1'b1;
        flush = '0;
        in_valid = '0;
        in_data = '0;
        out_ready = 1'b0;
        drive(1, 2'b00, 64'd0, 2'b00, 0);
        drive(1, 2'b00, 64'd0, 2'b00, 0);
        drive(0, 2'b00, 64'd0, 2'b00, 0);
        pin_out("reset", 2'b00, 64'd0, 2'd0, 1'b1);
        check("reset noskid ready", {63'd0, rdy0}, 64'd1);

        // streaming, one group per cycle
        for (int i = 0; i < 4; i++) begin
            g = {32'(i * 2 + 1), 32'(i * 2)} | 64'h5500_0000_3300_0000;
            drive(0, 2'b11, g, 2'b00, 1);
            pin_out("stream", 2'b11, g, 2'd1, 1'b1);
        end
        drive(0, 2'b00, 64'd0, 2'b00, 1);
        pin_out("stream drained", 2'b00, 64'd0, 2'd0, 1'b1);

        // stall: G1 in M, G2 absorbed into S, G3 held off
        drive(0, 2'b11, G1, 2'b00, 0);
        pin_out("stall g1", 2'b11, G1, 2'd1, 1'b1);
        drive(0, 2'b11, G2, 2'b00, 0);
        pin_out("stall g2", 2'b11, G1, 2'd2, 1'b0);
        drive(0, 2'b11, G3, 2'b00, 0);
        pin_out("stall g3 held", 2'b11, G1, 2'd2, 1'b0);
        drive(0, 2'b11, G3, 2'b00, 1);
        pin_out("release g2", 2'b11, G2, 2'd1, 1'b1);
        drive(0, 2'b11, G3, 2'b00, 1);
        pin_out("release g3", 2'b11, G3, 2'd1, 1'b1);
        drive(0, 2'b00, 64'd0, 2'b00, 1);
        pin_out("release drained", 2'b00, 64'd0, 2'd0, 1'b1);

        // partial flush of a stalled group
        drive(0, 2'b11, {32'h22, 32'h11}, 2'b00, 0);
        drive(0, 2'b00, 64'd0, 2'b00, 0);
        drive(0, 2'b00, 64'd0, 2'b10, 0);
        pin_out("partial flush", 2'b01, {32'h0, 32'h11}, 2'd1, 1'b1);
        drive(0, 2'b00, 64'd0, 2'b00, 1);

        // full flush with M and S occupied
        drive(0, 2'b11, XY, 2'b00, 0);
        drive(0, 2'b11, PQ, 2'b00, 0);
        pin_out("full setup", 2'b11, XY, 2'd2, 1'b0);
        drive(0, 2'b00, 64'd0, 2'b11, 0);
        pin_out("full flush", 2'b00, 64'd0, 2'd0, 1'b1);

        // lane0 flush with M and S occupied, then reset mid-stall
        drive(0, 2'b11, XY, 2'b00, 0);
        drive(0, 2'b11, PQ, 2'b00, 0);
        drive(0, 2'b00, 64'd0, 2'b01, 0);
        pin_out("lane0 flush m", 2'b10, {32'hBB, 32'h0}, 2'd2, 1'b0);
        drive(0, 2'b00, 64'd0, 2'b00, 1);
        pin_out("lane0 flush s", 2'b10, {32'hDD, 32'h0}, 2'd1, 1'b1);
        drive(0, 2'b11, G1, 2'b00, 0);
        drive(0, 2'b11, G2, 2'b00, 0);
        drive(1, 2'b11, G3, 2'b00, 0);
        pin_out("rst mid-stall", 2'b00, 64'd0, 2'd0, 1'b1);

        // flush on the same cycle as accept
        drive(0, 2'b11, {32'h0000_BEEF, 32'h0000_CAFE}, 2'b01, 0);
        pin_out("flush at accept", 2'b10, {32'h0000_BEEF, 32'h0}, 2'd1, 1'b1);

        // no-skid ready follows out_ready combinationally
        check("noskid ready stalled", {63'd0, rdy0}, 64'd0);
        out_ready = 1'b1;
        in_valid  = 2'b00;
        #1;
        check("noskid ready released", {63'd0, rdy0}, 64'd1);
        drive(0, 2'b00, 64'd0, 2'b00, 1);
        pin_out("final drain", 2'b00, 64'd0, 2'd0, 1'b1);
        drive(0, 2'b00, 64'd0, 2'b00, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
